// File: rtl/bus_arb_pkg.sv
// Shared NES bus definitions: bus owner codes, arbiter state codes, and the
// round-robin pick used when HCI and LDR request together.
// No logic of its own; imported by bus_arb.
package bus_arb_pkg;

  // Owner code as seen on owner_out; the top-level bus mux switches on it.
  typedef enum logic [1:0] {
    OWN_CPU  = 2'd0,
    OWN_HCI  = 2'd1,
    OWN_LDR  = 2'd2,
    OWN_NONE = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_CPU_OWN = 2'd0,
    ST_STALL   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_GRANT   = 2'd3
  } state_e;

  // Drain counter width; covers DRAIN_CYC up to 15.
  localparam int unsigned DRAIN_W = 4;

  // On a tie, the winner is whichever requester was not granted last.
  function automatic owner_e rr_pick(input logic hci_req, input logic ldr_req,
                                     input owner_e last);
    owner_e w;
    w = OWN_NONE;
    if (hci_req && ldr_req) w = (last == OWN_HCI) ? OWN_LDR : OWN_HCI;
    else if (hci_req)       w = OWN_HCI;
    else if (ldr_req)       w = OWN_LDR;
    return w;
  endfunction

endpackage

// File: rtl/bus_arb.sv
// Purpose: shares the cpumc bus between the rp2a03 CPU, the HCI debug host and the cartridge loader.
// Latency: a request seen in CPU_OWN with the CPU reading is granted 2+DRAIN_CYC cycles later.
// Backpressure: CPU is held off via cpu_rdy_out; a granted requester keeps the bus until it drops req.
//
// Ports:
//   clk_in, rst_in                      clock, synchronous active-high reset
//   cpu_a_in/cpu_r_nw_in/cpu_d_in       CPU bus request; cpu_rdy_out stalls the CPU
//   hci_req_in/hci_gnt_out, hci_*_in    debug host request/grant and bus request
//   ldr_req_in/ldr_gnt_out, ldr_*_in    cartridge loader request/grant and bus request
//   bus_a_out/bus_r_nw_out/bus_d_out    shared bus drive
//   owner_out                           0 CPU, 1 HCI, 2 LDR, 3 none (stall/drain)
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 2  // 1..15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  input  logic        hci_req_in,
  output logic        hci_gnt_out,
  input  logic [15:0] hci_a_in,
  input  logic        hci_r_nw_in,
  input  logic [7:0]  hci_d_in,
  input  logic        ldr_req_in,
  output logic        ldr_gnt_out,
  input  logic [15:0] ldr_a_in,
  input  logic        ldr_r_nw_in,
  input  logic [7:0]  ldr_d_in,
  output logic [15:0] bus_a_out,
  output logic        bus_r_nw_out,
  output logic [7:0]  bus_d_out,
  output logic [1:0]  owner_out
);

  // The counter is loaded on DRAIN entry and DRAIN ends on the cycle it reads zero,
  // so loading DRAIN_CYC-1 gives exactly DRAIN_CYC drain cycles.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);

  state_e             st_q, st_d;
  owner_e             own_q, own_d;
  owner_e             last_q, last_d;
  logic [DRAIN_W-1:0] cnt_q, cnt_d;
  logic               rdy_q, hci_gnt_q, ldr_gnt_q;

  owner_e winner;
  logic   win_req;

  assign winner  = rr_pick(hci_req_in, ldr_req_in, last_q);
  assign win_req = (own_q == OWN_HCI) ? hci_req_in : ldr_req_in;

  always_comb begin
    st_d   = st_q;
    own_d  = own_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    unique case (st_q)
      ST_CPU_OWN: begin
        if (hci_req_in || ldr_req_in) begin
          st_d  = ST_STALL;
          own_d = OWN_NONE;
        end
      end
      // RDY only halts the 6502 on a read, so wait for one before draining.
      ST_STALL: begin
        if (cpu_r_nw_in) begin
          st_d  = ST_DRAIN;
          cnt_d = DRAIN_LOAD;
        end
      end
      // Arbitration is sampled only here; requests changing later do not move the grant.
      ST_DRAIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (winner != OWN_NONE) begin
          st_d   = ST_GRANT;
          own_d  = winner;
          last_d = winner;
        end else begin
          st_d  = ST_CPU_OWN;
          own_d = OWN_CPU;
        end
      end
      // No pre-emption: only the owner releasing its request ends the grant.
      default: begin
        if (!win_req) begin
          st_d  = ST_DRAIN;
          own_d = OWN_NONE;
          cnt_d = DRAIN_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q      <= ST_CPU_OWN;
      own_q     <= OWN_CPU;
      last_q    <= OWN_LDR;  // makes HCI the first tie winner
      cnt_q     <= '0;
      rdy_q     <= 1'b1;
      hci_gnt_q <= 1'b0;
      ldr_gnt_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      own_q     <= own_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rdy_q     <= (st_d == ST_CPU_OWN);
      hci_gnt_q <= (st_d == ST_GRANT) && (own_d == OWN_HCI);
      ldr_gnt_q <= (st_d == ST_GRANT) && (own_d == OWN_LDR);
    end
  end

  assign cpu_rdy_out = rdy_q;
  assign hci_gnt_out = hci_gnt_q;
  assign ldr_gnt_out = ldr_gnt_q;
  assign owner_out   = own_q;

  // With no owner the CPU address stays on the bus as a dummy read. While
  // still in STALL the CPU may be mid write sequence (it ignores RDY on
  // writes), so those writes pass through; once it reads, or in DRAIN, the
  // bus is forced to read with data zero.
  logic none_rnw;
  assign none_rnw = (st_q == ST_STALL) ? cpu_r_nw_in : 1'b1;

  always_comb begin
    bus_a_out    = cpu_a_in;
    bus_r_nw_out = cpu_r_nw_in;
    bus_d_out    = cpu_d_in;
    unique case (own_q)
      OWN_CPU: begin
        bus_a_out    = cpu_a_in;
      end
      OWN_HCI: begin
        bus_a_out    = hci_a_in;
        bus_r_nw_out = hci_r_nw_in;
        bus_d_out    = hci_d_in;
      end
      OWN_LDR: begin
        bus_a_out    = ldr_a_in;
        bus_r_nw_out = ldr_r_nw_in;
        bus_d_out    = ldr_d_in;
      end
      default: begin
        bus_r_nw_out = none_rnw;
        bus_d_out    = none_rnw ? 8'h00 : cpu_d_in;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: directed scenarios plus a randomized run against a cycle model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// No backpressure of its own; the bench always accepts DUT outputs.
module tb_bus_arb;

  localparam int unsigned DRAIN_CYC = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] cpu_a_in;
  logic        cpu_r_nw_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_rdy_out;
  logic        hci_req_in, hci_gnt_out, hci_r_nw_in;
  logic [15:0] hci_a_in;
  logic [7:0]  hci_d_in;
  logic        ldr_req_in, ldr_gnt_out, ldr_r_nw_in;
  logic [15:0] ldr_a_in;
  logic [7:0]  ldr_d_in;
  logic [15:0] bus_a_out;
  logic        bus_r_nw_out;
  logic [7:0]  bus_d_out;
  logic [1:0]  owner_out;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arb #(.DRAIN_CYC(DRAIN_CYC)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .cpu_a_in(cpu_a_in), .cpu_r_nw_in(cpu_r_nw_in), .cpu_d_in(cpu_d_in),
    .cpu_rdy_out(cpu_rdy_out),
    .hci_req_in(hci_req_in), .hci_gnt_out(hci_gnt_out), .hci_a_in(hci_a_in),
    .hci_r_nw_in(hci_r_nw_in), .hci_d_in(hci_d_in),
    .ldr_req_in(ldr_req_in), .ldr_gnt_out(ldr_gnt_out), .ldr_a_in(ldr_a_in),
    .ldr_r_nw_in(ldr_r_nw_in), .ldr_d_in(ldr_d_in),
    .bus_a_out(bus_a_out), .bus_r_nw_out(bus_r_nw_out), .bus_d_out(bus_d_out),
    .owner_out(owner_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_in);
  endtask

  // Leaves the bench just after an edge with rst low: cycle 0 of a scenario.
  task automatic do_reset();
    rst_in = 1'b1; hci_req_in = 1'b0; ldr_req_in = 1'b0; cpu_r_nw_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; hci_req_in = 1'b1; ldr_req_in = 1'b1;
    cpu_a_in = 16'h5555; cpu_d_in = 8'h3A; cpu_r_nw_in = 1'b0;
    step();
    step();
    mid();
    n_tests++;
    if ({owner_out, cpu_rdy_out, hci_gnt_out, ldr_gnt_out} !== 5'b00_1_0_0) begin
      n_fail++;
      $display("FAIL reset_ctrl: owner=%0d rdy=%b hgnt=%b lgnt=%b, want owner=0 rdy=1 gnts=0",
               owner_out, cpu_rdy_out, hci_gnt_out, ldr_gnt_out);
    end
    n_tests++;
    if ({bus_a_out, bus_r_nw_out, bus_d_out} !== {16'h5555, 1'b0, 8'h3A}) begin
      n_fail++;
      $display("FAIL reset_bus: a=%h rnw=%b d=%h, want a=5555 rnw=0 d=3a",
               bus_a_out, bus_r_nw_out, bus_d_out);
    end
    hci_req_in = 1'b0; ldr_req_in = 1'b0; cpu_r_nw_in = 1'b1;
  endtask

  // HCI request with CPU reading: rdy low at cycle 1, grant at cycle 2+DRAIN_CYC.
  task automatic test_hci_latency();
    logic [1:0] exp_own [0:8];
    logic [15:0] exp_a;
    exp_own = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0};
    do_reset();
    cpu_a_in = 16'h1234; cpu_r_nw_in = 1'b1; cpu_d_in = 8'h11;
    hci_a_in = 16'h8000; hci_r_nw_in = 1'b1; hci_d_in = 8'h00;
    hci_req_in = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      if (c == 5) hci_req_in = 1'b0;
      mid();
      n_tests++;
      if (owner_out !== exp_own[c] || cpu_rdy_out !== (exp_own[c] == 2'd0) ||
          hci_gnt_out !== (exp_own[c] == 2'd1) || ldr_gnt_out !== 1'b0) begin
        n_fail++;
        $display("FAIL hci_latency cyc%0d: owner=%0d rdy=%b hgnt=%b lgnt=%b, want owner=%0d",
                 c, owner_out, cpu_rdy_out, hci_gnt_out, ldr_gnt_out, exp_own[c]);
      end
      exp_a = (exp_own[c] == 2'd1) ? 16'h8000 : 16'h1234;
      n_tests++;
      if (bus_a_out !== exp_a) begin
        n_fail++;
        $display("FAIL hci_latency_bus cyc%0d: bus_a=%h, want %h", c, bus_a_out, exp_a);
      end
    end
  endtask

  // Three CPU writes keep STALL; writes reach the bus, DRAIN forces a read.
  task automatic test_cpu_writes();
    logic [1:0] exp_own [0:9];
    logic       exp_rnw [0:9];
    logic [7:0] exp_d   [0:9];
    exp_own = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd0};
    exp_rnw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_d   = '{8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 8'hC3};
    do_reset();
    cpu_a_in = 16'h01FD; hci_a_in = 16'h4016; hci_r_nw_in = 1'b0; hci_d_in = 8'h77;
    hci_req_in = 1'b1; cpu_r_nw_in = 1'b0; cpu_d_in = 8'h5A;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) step();
      if (c == 3) cpu_r_nw_in = 1'b1;
      if (c == 4) begin cpu_r_nw_in = 1'b0; cpu_d_in = 8'hC3; end
      if (c == 6) begin cpu_r_nw_in = 1'b1; hci_req_in = 1'b0; end
      mid();
      n_tests++;
      if (owner_out !== exp_own[c] || bus_r_nw_out !== exp_rnw[c] || bus_d_out !== exp_d[c] ||
          hci_gnt_out !== (exp_own[c] == 2'd1)) begin
        n_fail++;
        $display("FAIL cpu_writes cyc%0d: owner=%0d rnw=%b d=%h hgnt=%b, want owner=%0d rnw=%b d=%h",
                 c, owner_out, bus_r_nw_out, bus_d_out, hci_gnt_out, exp_own[c], exp_rnw[c], exp_d[c]);
      end
    end
  endtask

  // Simultaneous requests from reset: HCI first, then LDR after one DRAIN, rdy low throughout.
  task automatic test_round_robin();
    logic [1:0]  exp_own [0:12];
    logic [15:0] exp_a;
    exp_own = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    do_reset();
    cpu_a_in = 16'h0F0F; cpu_r_nw_in = 1'b1;
    hci_a_in = 16'h1111; ldr_a_in = 16'h2222; ldr_r_nw_in = 1'b0; ldr_d_in = 8'h99;
    hci_req_in = 1'b1; ldr_req_in = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) step();
      if (c == 5) hci_req_in = 1'b0;
      if (c == 9) ldr_req_in = 1'b0;
      mid();
      n_tests++;
      if (owner_out !== exp_own[c] || cpu_rdy_out !== (exp_own[c] == 2'd0) ||
          hci_gnt_out !== (exp_own[c] == 2'd1) || ldr_gnt_out !== (exp_own[c] == 2'd2)) begin
        n_fail++;
        $display("FAIL round_robin cyc%0d: owner=%0d rdy=%b hgnt=%b lgnt=%b, want owner=%0d",
                 c, owner_out, cpu_rdy_out, hci_gnt_out, ldr_gnt_out, exp_own[c]);
      end
      exp_a = (exp_own[c] == 2'd1) ? 16'h1111 : (exp_own[c] == 2'd2) ? 16'h2222 : 16'h0F0F;
      n_tests++;
      if (bus_a_out !== exp_a) begin
        n_fail++;
        $display("FAIL round_robin_bus cyc%0d: bus_a=%h, want %h", c, bus_a_out, exp_a);
      end
    end
  endtask

  // One-cycle LDR pulse: full stall/drain then back to the CPU with no grant.
  task automatic test_ldr_pulse();
    logic [1:0] exp_own [0:4];
    exp_own = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0};
    do_reset();
    cpu_r_nw_in = 1'b1; ldr_req_in = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) step();
      if (c == 1) ldr_req_in = 1'b0;
      mid();
      n_tests++;
      if (owner_out !== exp_own[c] || cpu_rdy_out !== (exp_own[c] == 2'd0) ||
          hci_gnt_out !== 1'b0 || ldr_gnt_out !== 1'b0) begin
        n_fail++;
        $display("FAIL ldr_pulse cyc%0d: owner=%0d rdy=%b hgnt=%b lgnt=%b, want owner=%0d no gnt",
                 c, owner_out, cpu_rdy_out, hci_gnt_out, ldr_gnt_out, exp_own[c]);
      end
    end
  endtask

  // Reset during an LDR grant, then during a DRAIN: both return straight to the CPU.
  task automatic test_reset_mid();
    logic [1:0]  exp_own [0:11];
    logic [15:0] exp_a;
    exp_own = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0};
    do_reset();
    cpu_a_in = 16'h3C3C; cpu_r_nw_in = 1'b1; ldr_a_in = 16'hABCD; ldr_r_nw_in = 1'b1;
    ldr_req_in = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) step();
      if (c == 5) rst_in = 1'b1;
      if (c == 6) begin rst_in = 1'b0; ldr_req_in = 1'b0; end
      if (c == 7) hci_req_in = 1'b1;
      if (c == 9) begin rst_in = 1'b1; hci_req_in = 1'b0; end
      if (c == 10) rst_in = 1'b0;
      mid();
      n_tests++;
      exp_a = (exp_own[c] == 2'd2) ? 16'hABCD : 16'h3C3C;
      if (owner_out !== exp_own[c] || cpu_rdy_out !== (exp_own[c] == 2'd0) ||
          ldr_gnt_out !== (exp_own[c] == 2'd2) || hci_gnt_out !== 1'b0 || bus_a_out !== exp_a) begin
        n_fail++;
        $display("FAIL reset_mid cyc%0d: owner=%0d rdy=%b lgnt=%b hgnt=%b a=%h, want owner=%0d a=%h",
                 c, owner_out, cpu_rdy_out, ldr_gnt_out, hci_gnt_out, bus_a_out, exp_own[c], exp_a);
      end
    end
  endtask

  // Random requests/resets against a model that tracks who holds the bus,
  // whether we still wait for a CPU read, and how many drain cycles remain.
  task automatic test_random();
    int          who, drain_left, last;
    bit          waiting;
    logic [15:0] e_a;
    logic        e_rnw;
    logic [7:0]  e_d;
    do_reset();
    who = 0; waiting = 1'b0; drain_left = 0; last = 2;
    for (int i = 0; i < 10000; i++) begin
      if (i > 0) step();
      rst_in      = ($urandom_range(499) == 0);
      hci_req_in  = hci_req_in ? ($urandom_range(7) != 0) : ($urandom_range(15) == 0);
      ldr_req_in  = ldr_req_in ? ($urandom_range(7) != 0) : ($urandom_range(15) == 0);
      cpu_r_nw_in = ($urandom_range(3) != 0);
      cpu_a_in = 16'($urandom); cpu_d_in = 8'($urandom);
      hci_a_in = 16'($urandom); hci_d_in = 8'($urandom); hci_r_nw_in = 1'($urandom);
      ldr_a_in = 16'($urandom); ldr_d_in = 8'($urandom); ldr_r_nw_in = 1'($urandom);
      mid();
      case (who)
        0:       begin e_a = cpu_a_in; e_rnw = cpu_r_nw_in; e_d = cpu_d_in; end
        1:       begin e_a = hci_a_in; e_rnw = hci_r_nw_in; e_d = hci_d_in; end
        2:       begin e_a = ldr_a_in; e_rnw = ldr_r_nw_in; e_d = ldr_d_in; end
        default: begin
          e_a = cpu_a_in;
          e_rnw = waiting ? cpu_r_nw_in : 1'b1;
          e_d = e_rnw ? 8'h00 : cpu_d_in;
        end
      endcase
      n_tests++;
      if ({owner_out, cpu_rdy_out, hci_gnt_out, ldr_gnt_out} !==
          {2'(who), (who == 0), (who == 1), (who == 2)}) begin
        n_fail++;
        $display("FAIL rand_ctrl i=%0d: owner=%0d rdy=%b hgnt=%b lgnt=%b, want owner=%0d",
                 i, owner_out, cpu_rdy_out, hci_gnt_out, ldr_gnt_out, who);
      end
      n_tests++;
      if ({bus_a_out, bus_r_nw_out, bus_d_out} !== {e_a, e_rnw, e_d}) begin
        n_fail++;
        $display("FAIL rand_bus i=%0d: a=%h rnw=%b d=%h, want a=%h rnw=%b d=%h",
                 i, bus_a_out, bus_r_nw_out, bus_d_out, e_a, e_rnw, e_d);
      end
      n_tests++;
      if (hci_gnt_out && ldr_gnt_out) begin
        n_fail++;
        $display("FAIL rand_gnt_mutex i=%0d: hgnt=%b lgnt=%b, want not both", i, hci_gnt_out, ldr_gnt_out);
      end
      n_tests++;
      if ((hci_gnt_out || ldr_gnt_out) && cpu_rdy_out) begin
        n_fail++;
        $display("FAIL rand_gnt_rdy i=%0d: rdy=%b with a gnt, want 0", i, cpu_rdy_out);
      end
      n_tests++;
      if (hci_gnt_out !== (owner_out == 2'd1) || ldr_gnt_out !== (owner_out == 2'd2)) begin
        n_fail++;
        $display("FAIL rand_owner_gnt i=%0d: owner=%0d hgnt=%b lgnt=%b, want consistent",
                 i, owner_out, hci_gnt_out, ldr_gnt_out);
      end
      // Advance the model across the coming edge.
      if (rst_in) begin
        who = 0; waiting = 1'b0; drain_left = 0; last = 2;
      end else if (who == 0) begin
        if (hci_req_in || ldr_req_in) begin who = 3; waiting = 1'b1; end
      end else if (who == 1 || who == 2) begin
        if (!((who == 1) ? hci_req_in : ldr_req_in)) begin who = 3; drain_left = DRAIN_CYC; end
      end else if (waiting) begin
        if (cpu_r_nw_in) begin waiting = 1'b0; drain_left = DRAIN_CYC; end
      end else begin
        drain_left--;
        if (drain_left == 0) begin
          if (hci_req_in && ldr_req_in) who = 3 - last;
          else if (hci_req_in)          who = 1;
          else if (ldr_req_in)          who = 2;
          else                          who = 0;
          if (who != 0) last = who;
        end
      end
    end
    rst_in = 1'b0; hci_req_in = 1'b0; ldr_req_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    cpu_a_in = '0; cpu_r_nw_in = 1'b1; cpu_d_in = '0;
    hci_req_in = 1'b0; hci_a_in = '0; hci_r_nw_in = 1'b1; hci_d_in = '0;
    ldr_req_in = 1'b0; ldr_a_in = '0; ldr_r_nw_in = 1'b1; ldr_d_in = '0;
    test_reset();
    test_hci_latency();
    test_cpu_writes();
    test_round_robin();
    test_ldr_pulse();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
